// File: rtl/clk_div_sched.sv
// Programmable even-ratio clock divider. Divisor changes are queued and
// applied only at a period boundary, so div_clk never glitches.
module clk_div_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             div_tick,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_reg;
    logic [WIDTH-2:0] cnt_reg;
    logic [WIDTH-1:0] pend_reg;
    logic [WIDTH-1:0] cur_div_reg;
    logic             div_clk_reg;
    logic             div_tick_reg;
    logic             cfg_err_reg;

    logic             accept;
    logic             legal;
    logic [WIDTH-2:0] half_m1;
    logic             at_end;
    logic             boundary;

    // Zero and every even value are legal, so only the LSB matters.
    assign accept   = cfg_valid && cfg_ready;
    assign legal    = ~cfg_div[0];
    assign half_m1  = cur_div_reg[WIDTH-1:1] - (WIDTH-1)'(1);
    assign at_end   = (cnt_reg == half_m1);
    assign boundary = at_end && !div_clk_reg;

    assign cfg_ready = (state_reg != PEND);
    assign cfg_err   = cfg_err_reg;
    assign div_clk   = div_clk_reg;
    assign div_tick  = div_tick_reg;
    assign cur_div   = cur_div_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            pend_reg     <= '0;
            cur_div_reg  <= '0;
            div_clk_reg  <= 1'b0;
            div_tick_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            cfg_err_reg  <= accept && !legal;
            div_tick_reg <= 1'b0;

            // Free-running half-period counter; only meaningful while dividing.
            if (state_reg != IDLE) begin
                if (at_end) begin
                    cnt_reg      <= '0;
                    div_clk_reg  <= ~div_clk_reg;
                    div_tick_reg <= ~div_clk_reg;
                end else begin
                    cnt_reg <= cnt_reg + (WIDTH-1)'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (accept && legal && (cfg_div != '0)) begin
                        state_reg    <= RUN;
                        cnt_reg      <= '0;
                        div_clk_reg  <= 1'b1;
                        div_tick_reg <= 1'b1;
                        cur_div_reg  <= cfg_div;
                    end
                end
                RUN: begin
                    // A request landing on a boundary waits for the next one.
                    if (accept && legal) begin
                        pend_reg  <= cfg_div;
                        state_reg <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        pend_reg <= '0;
                        cnt_reg  <= '0;
                        if (pend_reg != '0) begin
                            state_reg    <= RUN;
                            div_clk_reg  <= 1'b1;
                            div_tick_reg <= 1'b1;
                            cur_div_reg  <= pend_reg;
                        end else begin
                            state_reg    <= IDLE;
                            div_clk_reg  <= 1'b0;
                            div_tick_reg <= 1'b0;
                            cur_div_reg  <= '0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: hand-computed per-cycle waveforms for
// start, divisor change, stop, illegal requests, boundary acceptance and reset.
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       div_clk;
    logic       div_tick;
    logic [7:0] cur_div;

    int vectors = 0;
    int miscompares = 0;

    clk_div_sched #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .div_clk  (div_clk),
        .div_tick (div_tick),
        .cur_div  (cur_div)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic start_div(input logic [7:0] n);
        cfg_valid = 1'b1; cfg_div = n;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({div_clk, div_tick, cfg_err, cfg_ready, cur_div} !== {4'b0001, 8'd0}) begin
            miscompares++;
            $display("FAIL reset: got clk=%b tick=%b err=%b rdy=%b cur=%0d want 0 0 0 1 0",
                     div_clk, div_tick, cfg_err, cfg_ready, cur_div);
        end
        $display("reset: clk=%b tick=%b err=%b rdy=%b cur=%0d", div_clk, div_tick, cfg_err, cfg_ready, cur_div);
    endtask

    task automatic test_start_n4();
        bit e_clk[8]  = '{1,1,0,0,1,1,0,0};
        bit e_tick[8] = '{1,0,0,0,1,0,0,0};
        do_reset();
        start_div(8'd4);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (div_clk !== e_clk[i] || div_tick !== e_tick[i] || cur_div !== 8'd4 || cfg_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL start_n4[%0d]: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=4 rdy=1",
                         i, div_clk, div_tick, cur_div, cfg_ready, e_clk[i], e_tick[i]);
            end
            step();
        end
        $display("start_n4: 8 cycles checked");
    endtask

    task automatic test_change_4_to_8();
        bit         e_clk[12]  = '{1,0,0,1,1,1,1,0,0,0,0,1};
        bit         e_tick[12] = '{0,0,0,1,0,0,0,0,0,0,0,1};
        bit         e_rdy[12]  = '{0,0,0,1,1,1,1,1,1,1,1,1};
        logic [7:0] e_cur[12]  = '{4,4,4,8,8,8,8,8,8,8,8,8};
        do_reset();
        start_div(8'd4);
        start_div(8'd8);
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (div_clk !== e_clk[i] || div_tick !== e_tick[i] || cfg_ready !== e_rdy[i] || cur_div !== e_cur[i]) begin
                miscompares++;
                $display("FAIL change_4_8[%0d]: got clk=%b tick=%b rdy=%b cur=%0d want clk=%b tick=%b rdy=%b cur=%0d",
                         i, div_clk, div_tick, cfg_ready, cur_div, e_clk[i], e_tick[i], e_rdy[i], e_cur[i]);
            end
            step();
        end
        $display("change_4_8: 12 cycles checked");
    endtask

    task automatic test_stop_n6();
        bit         e_clk[8] = '{1,0,0,0,0,0,0,0};
        bit         e_rdy[8] = '{0,0,0,0,1,1,1,1};
        logic [7:0] e_cur[8] = '{6,6,6,6,0,0,0,0};
        do_reset();
        start_div(8'd6);
        step();
        start_div(8'd0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (div_clk !== e_clk[i] || div_tick !== 1'b0 || cfg_ready !== e_rdy[i] || cur_div !== e_cur[i]) begin
                miscompares++;
                $display("FAIL stop_n6[%0d]: got clk=%b tick=%b rdy=%b cur=%0d want clk=%b tick=0 rdy=%b cur=%0d",
                         i, div_clk, div_tick, cfg_ready, cur_div, e_clk[i], e_rdy[i], e_cur[i]);
            end
            step();
        end
        $display("stop_n6: 8 cycles checked");
    endtask

    task automatic test_illegal();
        do_reset();
        // Zero and odd requests while idle: nothing starts, only odd flags an error.
        start_div(8'd0);
        vectors++;
        if (cfg_err !== 1'b0 || div_clk !== 1'b0 || cur_div !== 8'd0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_zero: got err=%b clk=%b cur=%0d rdy=%b want 0 0 0 1", cfg_err, div_clk, cur_div, cfg_ready);
        end
        start_div(8'd3);
        vectors++;
        if (cfg_err !== 1'b1 || div_clk !== 1'b0 || cur_div !== 8'd0) begin
            miscompares++;
            $display("FAIL idle_odd: got err=%b clk=%b cur=%0d want 1 0 0", cfg_err, div_clk, cur_div);
        end
        start_div(8'd4);
        start_div(8'd5);
        vectors++;
        if (cfg_err !== 1'b1 || div_clk !== 1'b1 || div_tick !== 1'b0 || cur_div !== 8'd4 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_n5: got err=%b clk=%b tick=%b cur=%0d rdy=%b want 1 1 0 4 1",
                     cfg_err, div_clk, div_tick, cur_div, cfg_ready);
        end
        step();
        vectors++;
        if (cfg_err !== 1'b0 || div_clk !== 1'b0 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL err_n5_clear: got err=%b clk=%b cur=%0d want 0 0 4", cfg_err, div_clk, cur_div);
        end
        start_div(8'd1);
        vectors++;
        if (cfg_err !== 1'b1 || div_clk !== 1'b0 || cur_div !== 8'd4 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_n1: got err=%b clk=%b cur=%0d rdy=%b want 1 0 4 1", cfg_err, div_clk, cur_div, cfg_ready);
        end
        step();
        vectors++;
        if (cfg_err !== 1'b0 || div_clk !== 1'b1 || div_tick !== 1'b1 || cur_div !== 8'd4) begin
            miscompares++;
            $display("FAIL err_n1_after: got err=%b clk=%b tick=%b cur=%0d want 0 1 1 4", cfg_err, div_clk, div_tick, cur_div);
        end
        $display("illegal: requests 0,3,5,1 checked");
    endtask

    task automatic test_boundary_accept();
        bit         e_clk[8]  = '{1,1,0,0,1,0,1,0};
        bit         e_tick[8] = '{1,0,0,0,1,0,1,0};
        bit         e_rdy[8]  = '{0,0,0,0,1,1,1,1};
        logic [7:0] e_cur[8]  = '{4,4,4,4,2,2,2,2};
        do_reset();
        start_div(8'd4);
        step(); step(); step();
        vectors++;
        if (div_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_setup: got clk=%b want 0", div_clk);
        end
        start_div(8'd2);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (div_clk !== e_clk[i] || div_tick !== e_tick[i] || cfg_ready !== e_rdy[i] || cur_div !== e_cur[i]) begin
                miscompares++;
                $display("FAIL boundary[%0d]: got clk=%b tick=%b rdy=%b cur=%0d want clk=%b tick=%b rdy=%b cur=%0d",
                         i, div_clk, div_tick, cfg_ready, cur_div, e_clk[i], e_tick[i], e_rdy[i], e_cur[i]);
            end
            step();
        end
        $display("boundary_accept: 8 cycles checked");
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        start_div(8'd4);
        start_div(8'd8);
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_entry: got rdy=%b want 0", cfg_ready);
        end
        reset = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd6;
        step();
        reset = 1'b0; cfg_valid = 1'b0;
        vectors++;
        if ({div_clk, div_tick, cfg_err, cfg_ready, cur_div} !== {4'b0001, 8'd0}) begin
            miscompares++;
            $display("FAIL pend_reset: got clk=%b tick=%b err=%b rdy=%b cur=%0d want 0 0 0 1 0",
                     div_clk, div_tick, cfg_err, cfg_ready, cur_div);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (div_clk !== 1'b0 || div_tick !== 1'b0 || cur_div !== 8'd0 || cfg_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL pend_discard[%0d]: got clk=%b tick=%b cur=%0d rdy=%b want 0 0 0 1",
                         i, div_clk, div_tick, cur_div, cfg_ready);
            end
        end
        $display("reset_in_pend: reset values and 10 idle cycles checked");
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
        test_reset();
        test_start_n4();
        test_change_4_to_8();
        test_stop_n6();
        test_illegal();
        test_boundary_accept();
        test_reset_in_pend();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
